// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Brief    : Shared SPI types and constants used by the master and slave sides.
// Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

  localparam int SPI_BYTE_BITS   = 8;
  localparam int SPI_MIN_CLK_DIV = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    NEXT  = 3'd4,
    HOLD  = 3'd5,
    GAP   = 3'd6
  } spi_state_e;

  function automatic int spi_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_phase_timer.sv
`default_nettype none
// ============================================================================
// Module   : spi_phase_timer
// Brief    : Loadable down-counter; o_done marks the last cycle of a phase.
// Revision : 1.0 - initial release
// ============================================================================
module spi_phase_timer #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_done
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_master
// Brief    : SPI mode-0 master, byte-stream in/out, cs_n framed by tx_last.
// Revision : 1.0 - initial release
// ============================================================================
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_tx_valid,
  output logic                     o_tx_ready,
  input  logic [SPI_BYTE_BITS-1:0] i_tx_data,
  input  logic                     i_tx_last,
  output logic                     o_rx_valid,
  output logic [SPI_BYTE_BITS-1:0] o_rx_data,
  output logic                     o_busy,
  output logic                     o_sclk,
  output logic                     o_cs_n,
  output logic                     o_mosi,
  input  logic                     i_miso
);

  localparam int               c_tmr_w    = $clog2(spi_max3(CLK_DIV, CS_SETUP, CS_HOLD) + 1);
  localparam logic [c_tmr_w-1:0] c_div_ld   = c_tmr_w'(CLK_DIV);
  localparam logic [c_tmr_w-1:0] c_setup_ld = c_tmr_w'(CS_SETUP);
  localparam logic [c_tmr_w-1:0] c_hold_ld  = c_tmr_w'(CS_HOLD);
  localparam logic [2:0]         c_last_bit = 3'(SPI_BYTE_BITS - 1);

  if (CLK_DIV < SPI_MIN_CLK_DIV) begin : g_chk_clk_div
    $error("spi_master: CLK_DIV must be >= %0d", SPI_MIN_CLK_DIV);
  end
  if (CS_SETUP < 1) begin : g_chk_cs_setup
    $error("spi_master: CS_SETUP must be >= 1");
  end
  if (CS_HOLD < 1) begin : g_chk_cs_hold
    $error("spi_master: CS_HOLD must be >= 1");
  end

  spi_state_e                   r_state;
  logic                         r_tx_ready;
  logic                         r_busy;
  logic                         r_sclk;
  logic                         r_cs_n;
  logic                         r_mosi;
  logic                         r_rx_valid;
  logic [SPI_BYTE_BITS-1:0]     r_rx_data;
  logic [SPI_BYTE_BITS-2:0]     r_shift_tx;
  logic [SPI_BYTE_BITS-2:0]     r_shift_rx;
  logic                         r_last;
  logic [2:0]                   r_bit_cnt;

  logic                         w_hs;
  logic                         w_tmr_load;
  logic [c_tmr_w-1:0]           w_tmr_val;
  logic                         w_tmr_done;

  assign w_hs = i_tx_valid & r_tx_ready;

  // Timer is reloaded on every phase change that needs a timed phase
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = c_div_ld;
    case (r_state)
      IDLE: begin
        w_tmr_load = w_hs;
        w_tmr_val  = c_setup_ld;
      end
      SETUP, LOW: w_tmr_load = w_tmr_done;
      HIGH: begin
        if (w_tmr_done) begin
          w_tmr_load = (r_bit_cnt != c_last_bit) || r_last;
          if (r_bit_cnt == c_last_bit) w_tmr_val = c_hold_ld;
        end
      end
      NEXT: w_tmr_load = w_hs;
      HOLD: begin
        w_tmr_load = w_tmr_done;
        w_tmr_val  = c_hold_ld;
      end
      default: w_tmr_load = 1'b0;
    endcase
  end

  spi_phase_timer #(
    .WIDTH (c_tmr_w)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_done     (w_tmr_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_tx_ready <= 1'b1;
      r_busy     <= 1'b0;
      r_sclk     <= 1'b0;
      r_cs_n     <= 1'b1;
      r_mosi     <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
      r_shift_tx <= '0;
      r_shift_rx <= '0;
      r_last     <= 1'b0;
      r_bit_cnt  <= '0;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_hs) begin
            r_shift_tx <= i_tx_data[SPI_BYTE_BITS-2:0];
            r_mosi     <= i_tx_data[SPI_BYTE_BITS-1];
            r_last     <= i_tx_last;
            r_cs_n     <= 1'b0;
            r_tx_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= SETUP;
          end
        end
        SETUP, LOW: begin
          if (w_tmr_done) begin
            r_sclk  <= 1'b1;
            r_state <= HIGH;
          end
        end
        HIGH: begin
          if (w_tmr_done) begin
            r_sclk     <= 1'b0;
            r_bit_cnt  <= r_bit_cnt + 1'b1;
            r_shift_rx <= {r_shift_rx[SPI_BYTE_BITS-3:0], i_miso};
            if (r_bit_cnt == c_last_bit) begin
              r_rx_data  <= {r_shift_rx, i_miso};
              r_rx_valid <= 1'b1;
              if (r_last) begin
                r_state <= HOLD;
              end else begin
                r_tx_ready <= 1'b1;
                r_state    <= NEXT;
              end
            end else begin
              // Falling edge: present the next bit a full half-period early
              r_mosi     <= r_shift_tx[SPI_BYTE_BITS-2];
              r_shift_tx <= {r_shift_tx[SPI_BYTE_BITS-3:0], 1'b0};
              r_state    <= LOW;
            end
          end
        end
        NEXT: begin
          if (w_hs) begin
            r_shift_tx <= i_tx_data[SPI_BYTE_BITS-2:0];
            r_mosi     <= i_tx_data[SPI_BYTE_BITS-1];
            r_last     <= i_tx_last;
            r_tx_ready <= 1'b0;
            r_state    <= LOW;
          end
        end
        HOLD: begin
          if (w_tmr_done) begin
            r_cs_n  <= 1'b1;
            r_mosi  <= 1'b0;
            r_state <= GAP;
          end
        end
        GAP: begin
          if (w_tmr_done) begin
            r_tx_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_tx_ready = r_tx_ready;
  assign o_rx_valid = r_rx_valid;
  assign o_rx_data  = r_rx_data;
  assign o_busy     = r_busy;
  assign o_sclk     = r_sclk;
  assign o_cs_n     = r_cs_n;
  assign o_mosi     = r_mosi;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master
// Brief    : Bench for spi_master: three parameterisations, slave model, checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master;

  localparam int NDUT = 3;

  function automatic int div_of(input int i);
    case (i)
      0: return 4;
      1: return 7;
      default: return 3;
    endcase
  endfunction

  function automatic int setup_of(input int i);
    case (i)
      0: return 2;
      1: return 5;
      default: return 1;
    endcase
  endfunction

  function automatic int hold_of(input int i);
    case (i)
      0: return 2;
      1: return 3;
      default: return 1;
    endcase
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NDUT-1:0]      tx_valid = '0;
  logic [NDUT-1:0]      tx_last  = '0;
  logic [NDUT-1:0][7:0] tx_data  = '0;
  logic [NDUT-1:0]      tx_ready, rx_valid, busy, sclk, cs_n, mosi;
  logic [NDUT-1:0][7:0] rx_data;
  logic [NDUT-1:0]      miso = '0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    spi_master #(
      .CLK_DIV  (div_of(g)),
      .CS_SETUP (setup_of(g)),
      .CS_HOLD  (hold_of(g))
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .i_tx_valid (tx_valid[g]),
      .o_tx_ready (tx_ready[g]),
      .i_tx_data  (tx_data[g]),
      .i_tx_last  (tx_last[g]),
      .o_rx_valid (rx_valid[g]),
      .o_rx_data  (rx_data[g]),
      .o_busy     (busy[g]),
      .o_sclk     (sclk[g]),
      .o_cs_n     (cs_n[g]),
      .o_mosi     (mosi[g]),
      .i_miso     (miso[g])
    );
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model and line monitor, sampled mid-cycle
  logic [NDUT-1:0] p_sclk = '0;
  logic [NDUT-1:0] p_cs_n = '1;
  int rise_cnt[NDUT], kbit[NDUT], cs_rise_cnt[NDUT], rx_cnt[NDUT];
  int cs_fall_cyc[NDUT], first_rise_cyc[NDUT], second_rise_cyc[NDUT], first_fall_cyc[NDUT];
  logic [7:0] mosi_cap[NDUT][8];
  logic [7:0] resp[NDUT][8];

  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      if (p_cs_n[d] && !cs_n[d]) begin
        cs_fall_cyc[d] <= cyc;
        rise_cnt[d]    <= 0;
        kbit[d]        <= 0;
        cs_rise_cnt[d] <= 0;
        rx_cnt[d]      <= 0;
        miso[d]        <= resp[d][0][7];
      end else begin
        if (!p_cs_n[d] && cs_n[d]) cs_rise_cnt[d] <= cs_rise_cnt[d] + 1;
        if (rx_valid[d]) rx_cnt[d] <= rx_cnt[d] + 1;
        if (!p_sclk[d] && sclk[d]) begin
          if (rise_cnt[d] == 0) first_rise_cyc[d] <= cyc;
          if (rise_cnt[d] == 1) second_rise_cyc[d] <= cyc;
          if (rise_cnt[d] < 64)
            mosi_cap[d][rise_cnt[d] / 8] <= {mosi_cap[d][rise_cnt[d] / 8][6:0], mosi[d]};
          rise_cnt[d] <= rise_cnt[d] + 1;
        end
        if (p_sclk[d] && !sclk[d]) begin
          if (kbit[d] == 0) first_fall_cyc[d] <= cyc;
          kbit[d] <= kbit[d] + 1;
          if (kbit[d] + 1 < 64)
            miso[d] <= resp[d][(kbit[d] + 1) / 8][7 - ((kbit[d] + 1) % 8)];
        end
      end
      p_sclk[d] <= sclk[d];
      p_cs_n[d] <= cs_n[d];
    end
  end

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic sig(input int which, input int d);
    case (which)
      0: return rx_valid[d];
      1: return tx_ready[d];
      2: return cs_n[d];
      default: return busy[d];
    endcase
  endfunction

  task automatic wait_sig(input string tag, input int d, input int which, input logic val,
                          input int budget, output int at);
    logic found;
    found = 1'b0;
    at    = -1;
    for (int i = 0; i < budget && !found; i++) begin
      if (sig(which, d) === val) begin
        found = 1'b1;
        at    = cyc;
      end else begin
        tick();
      end
    end
    chk({tag, "_seen"}, {31'd0, found}, 32'd1);
  endtask

  logic [7:0] tx_b[8];
  int         stall_b[8];

  // Drive a frame of n bytes and compare everything against timing arithmetic
  task automatic do_frame(input int d, input int n);
    int h, h0, at, exp_rx, last_rx;
    logic ok;
    wait_sig("ready", d, 1, 1'b1, 500, at);
    h0 = cyc;
    last_rx = 0;
    for (int i = 0; i < n; i++) begin
      h = cyc;
      tx_valid[d] = 1'b1;
      tx_data[d]  = tx_b[i];
      tx_last[d]  = (i == n - 1);
      tick();
      tx_valid[d] = 1'b0;
      tx_data[d]  = 8'($urandom);
      tx_last[d]  = 1'($urandom);
      exp_rx = h + 1 + ((i == 0) ? setup_of(d) : div_of(d)) + 15 * div_of(d);
      wait_sig("rx_valid", d, 0, 1'b1, 3000, at);
      chk("rx_cycle", at, exp_rx);
      chk("rx_data", {24'd0, rx_data[d]}, {24'd0, resp[d][i]});
      last_rx = at;
      if (i < n - 1) begin
        ok = 1'b1;
        for (int s = 0; s < stall_b[i]; s++) begin
          tick();
          if (sclk[d] !== 1'b0 || cs_n[d] !== 1'b0 || tx_ready[d] !== 1'b1 || rx_valid[d] !== 1'b0)
            ok = 1'b0;
        end
        chk("next_stall", {31'd0, ok}, 32'd1);
      end
    end
    wait_sig("cs_rise", d, 2, 1'b1, 200, at);
    chk("hold_len", at, last_rx + hold_of(d));
    wait_sig("busy_low", d, 3, 1'b0, 200, at);
    chk("gap_len", at, last_rx + 2 * hold_of(d));
    chk("idle_ready", {31'd0, tx_ready[d]}, 32'd1);
    chk("rise_cnt", rise_cnt[d], 8 * n);
    chk("cs_rises", cs_rise_cnt[d], 1);
    chk("rx_pulses", rx_cnt[d], n);
    for (int i = 0; i < n; i++) chk("mosi_byte", {24'd0, mosi_cap[d][i]}, {24'd0, tx_b[i]});
    chk("cs_fall", cs_fall_cyc[d], h0 + 1);
    chk("cs_setup", first_rise_cyc[d] - cs_fall_cyc[d], setup_of(d));
    chk("sclk_high", first_fall_cyc[d] - first_rise_cyc[d], div_of(d));
    chk("sclk_period", second_rise_cyc[d] - first_rise_cyc[d], 2 * div_of(d));
  endtask

  task automatic rand_bytes(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      tx_b[i]    = 8'($urandom);
      resp[d][i] = 8'($urandom);
      stall_b[i] = $urandom_range(0, 3);
    end
  endtask

  initial begin
    int at;
    for (int d = 0; d < NDUT; d++)
      for (int i = 0; i < 8; i++) resp[d][i] = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("rst_cs_n",     {31'd0, cs_n[0]},     32'd1);
    chk("rst_sclk",     {31'd0, sclk[0]},     32'd0);
    chk("rst_mosi",     {31'd0, mosi[0]},     32'd0);
    chk("rst_tx_ready", {31'd0, tx_ready[0]}, 32'd1);
    chk("rst_busy",     {31'd0, busy[0]},     32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid[0]}, 32'd0);
    chk("rst_rx_data",  {24'd0, rx_data[0]},  32'd0);

    // Single byte A5 / 3C
    tx_b[0] = 8'hA5; resp[0][0] = 8'h3C;
    do_frame(0, 1);

    // Three-byte frame, back-to-back handshakes coincide with rx_valid
    tx_b[0] = 8'h01; tx_b[1] = 8'h80; tx_b[2] = 8'hFF;
    resp[0][0] = 8'h5E; resp[0][1] = 8'hC1; resp[0][2] = 8'h07;
    stall_b[0] = 0; stall_b[1] = 0;
    do_frame(0, 3);

    // Minimum divider loopback
    tx_b[0] = 8'hC3; resp[2][0] = 8'h5A;
    do_frame(2, 1);

    // Long stall in NEXT
    rand_bytes(0, 2);
    stall_b[0] = 100;
    do_frame(0, 2);

    // Slow divider and long setup
    rand_bytes(1, 2);
    do_frame(1, 2);

    // Reset during bit 4
    tx_b[0] = 8'h3B; resp[0][0] = 8'hE4;
    tx_valid[0] = 1'b1; tx_data[0] = tx_b[0]; tx_last[0] = 1'b1;
    tick();
    tx_valid[0] = 1'b0;
    for (int i = 0; i < 300 && rise_cnt[0] < 5; i++) tick();
    chk("mid_bit4_reached", rise_cnt[0], 5);
    rst = 1'b1;
    #1;
    chk("mid_rst_cs_n",     {31'd0, cs_n[0]},     32'd1);
    chk("mid_rst_sclk",     {31'd0, sclk[0]},     32'd0);
    chk("mid_rst_mosi",     {31'd0, mosi[0]},     32'd0);
    chk("mid_rst_busy",     {31'd0, busy[0]},     32'd0);
    chk("mid_rst_tx_ready", {31'd0, tx_ready[0]}, 32'd1);
    chk("mid_rst_rx_data",  {24'd0, rx_data[0]},  32'd0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    tx_b[0] = 8'h96; resp[0][0] = 8'h69;
    do_frame(0, 1);

    // Randomised frames across all parameterisations
    for (int r = 0; r < 6; r++) begin
      int d, n;
      d = $urandom_range(0, NDUT - 1);
      n = $urandom_range(1, 4);
      rand_bytes(d, n);
      do_frame(d, n);
    end

    wait_sig("final_idle", 0, 3, 1'b0, 50, at);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
